// File: rtl/cpu_pkg.sv
// Shared definitions for the control unit: opcodes, FSM states and instruction layout.
package cpu_pkg;
  localparam int OPC_MSB = 15, OPC_LSB = 12;
  localparam int RD_MSB  = 11, RD_LSB  = 10;
  localparam int RS_MSB  = 9,  RS_LSB  = 8;
  localparam int IMM_MSB = 7,  IMM_LSB = 0;

  typedef enum logic [3:0] {
    OP_MOV = 4'h0, OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR, OP_XOR,
    OP_NOT, OP_SHL, OP_SHR, OP_LI, OP_INC, OP_JMP, OP_BRANCH, OP_HALT
  } opcode_t;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK, S_HALT
  } state_t;

  typedef struct packed {
    opcode_t    op;
    logic [1:0] rd;
    logic [1:0] rs;
    logic [7:0] imm;
  } instr_t;
endpackage

// File: rtl/cpu_if.sv
// Instruction-memory and ALU bus between the control unit and its datapath.
interface cpu_if;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic        imem_ready;
  logic [3:0]  alu_opcode;
  logic [7:0]  alu_op1;
  logic [7:0]  alu_op2;
  logic        alu_enable;
  logic [7:0]  alu_out;
  logic [15:0] alu_outmd;

  modport master (output imem_addr, alu_opcode, alu_op1, alu_op2, alu_enable,
                  input  imem_data, imem_ready, alu_out, alu_outmd);
  modport slave  (input  imem_addr, alu_opcode, alu_op1, alu_op2, alu_enable,
                  output imem_data, imem_ready, alu_out, alu_outmd);
endinterface

// File: rtl/reg_file.sv
// 4x8 register file, two combinational reads, one write port with optional high-byte write to wa+1.
module reg_file (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] ra,
  input  logic [1:0] rb,
  output logic [7:0] rdata_a,
  output logic [7:0] rdata_b,
  input  logic       we,
  input  logic       we_hi,
  input  logic [1:0] wa,
  input  logic [7:0] wdata,
  input  logic [7:0] wdata_hi
);
  logic [3:0][7:0] regs;

  assign rdata_a = regs[ra];
  assign rdata_b = regs[rb];

  // wa + 1 wraps naturally in 2 bits, so r3's high byte lands in r0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) regs <= '0;
    else begin
      if (we)          regs[wa]         <= wdata;
      if (we && we_hi) regs[wa + 2'd1] <= wdata_hi;
    end
  end
endmodule

// File: rtl/control_unit.sv
// Multi-cycle control unit: FETCH/DECODE/EXECUTE/WRITEBACK sequencing around an external ALU.
module control_unit import cpu_pkg::*; #(
  parameter logic [7:0] PC_RESET = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  cpu_if.master      bus,
  output logic [7:0] pc,
  output logic       halted,
  output logic       error
);
  state_t      state, state_nx;
  instr_t      ir;
  logic [3:0]  opc_q;
  logic [7:0]  op1_q, op2_q, res_q, rd_val, rs_val, wdata, pc_nx;
  logic [15:0] resmd_q;
  logic        we, we_hi, div0;

  reg_file u_rf (
    .clk(clk), .reset(reset), .ra(ir.rd), .rb(ir.rs), .rdata_a(rd_val), .rdata_b(rs_val),
    .we(we), .we_hi(we_hi), .wa(ir.rd), .wdata(wdata), .wdata_hi(resmd_q[15:8])
  );

  assign bus.imem_addr  = pc;
  assign bus.alu_enable = (state == S_EXECUTE);
  assign bus.alu_opcode = opc_q;
  assign bus.alu_op1    = op1_q;
  assign bus.alu_op2    = op2_q;
  assign halted         = (state == S_HALT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      pc      <= PC_RESET;
      ir      <= '0;
      opc_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      res_q   <= '0;
      resmd_q <= '0;
      error   <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_FETCH && bus.imem_ready) ir <= bus.imem_data;
      // ALU operand registers double as the held bus values outside EXECUTE
      if (state == S_DECODE && ir.op != OP_HALT) begin
        opc_q <= ir.op;
        op1_q <= (ir.op == OP_LI) ? ir.imm : (ir.op == OP_INC) ? rs_val : rd_val;
        op2_q <= rs_val;
      end
      if (state == S_EXECUTE) begin
        res_q   <= bus.alu_out;
        resmd_q <= bus.alu_outmd;
      end
      if (state == S_WRITEBACK) begin
        pc <= pc_nx;
        if (div0) error <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    we       = 1'b0;
    we_hi    = 1'b0;
    wdata    = res_q;
    pc_nx    = pc + 8'd1;
    div0     = (ir.op == OP_DIV) && (op2_q == 8'd0);
    unique case (state)
      S_IDLE:    if (run) state_nx = S_FETCH;
      S_FETCH:   if (bus.imem_ready) state_nx = S_DECODE;
      S_DECODE:  state_nx = (ir.op == OP_HALT) ? S_HALT : S_EXECUTE;
      S_EXECUTE: state_nx = S_WRITEBACK;
      S_WRITEBACK: begin
        state_nx = run ? S_FETCH : S_IDLE;
        case (ir.op)
          OP_MUL: begin we = 1'b1; we_hi = 1'b1; wdata = resmd_q[7:0]; end
          OP_DIV:
            if (div0) begin
              state_nx = S_HALT;
              pc_nx    = pc;
            end else begin
              we    = 1'b1;
              wdata = resmd_q[7:0];
            end
          OP_JMP:    pc_nx = ir.imm;
          OP_BRANCH: if (op1_q == 8'd0) pc_nx = ir.imm;
          default:   we = 1'b1;
        endcase
      end
      S_HALT:  state_nx = S_HALT;
      default: state_nx = S_IDLE;
    endcase
  end
endmodule
